// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider.
//   DIV_STATE_W : width of the divider FSM state encoding
//   div_state_e : divider FSM states (IDLE, CALC, FIX, DONE)
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_STATE_W = 2;

    typedef enum logic [DIV_STATE_W-1:0] {
        IDLE = 2'd0,  // waiting for start
        CALC = 2'd1,  // one restoring step per clock
        FIX  = 2'd2,  // sign fix-up and result write
        DONE = 2'd3   // one-cycle done pulse
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_abs_neg.sv
// ----------------------------------------------------------------------------
// div_abs_neg
// Combinational conditional two's-complement negation. It is used both to
// take operand magnitudes and to restore result signs.
//   value_i  [WIDTH-1:0] : input value
//   negate_i             : 1 = output -value_i, 0 = output value_i
//   value_o  [WIDTH-1:0] : result
// ----------------------------------------------------------------------------
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] value_o
);

    // The most negative value maps to itself. Read as unsigned, that is still
    // the correct magnitude.
    assign value_o = negate_i ? ((~value_i) + WIDTH'(1)) : value_i;

endmodule : div_abs_neg

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider (signed or unsigned) with a start/busy/done
// handshake, divide-by-zero detection and defined overflow results.
//
// Optional feature macro: DIV_EARLY_ZERO_EN
//   When defined, a divide with |dividend| < |divisor| completes at the
//   accepting edge with quotient 0 and remainder = dividend.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : request; only sampled in IDLE
//   op_signed    : 1 = two's-complement divide, 0 = unsigned (sampled with start)
//   dividend     : [WIDTH-1:0] sampled with start
//   divisor      : [WIDTH-1:0] sampled with start
//   busy         : high whenever the FSM is not in IDLE
//   done         : one-cycle pulse; results valid from this cycle on
//   quotient     : [WIDTH-1:0] held until the next result write
//   remainder    : [WIDTH-1:0] held until the next result write
//   dataOut      : [2*WIDTH-1:0] {remainder, quotient}
//   div_by_zero  : set with done when the divisor was zero
// ----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // The upper half holds the partial remainder and the lower half holds the
    // dividend bits being shifted out. Quotient bits shift into the lower half.
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   abs_dvd, abs_dvs;
    logic [WIDTH-1:0]   fix_quo, fix_rem;
    logic [WIDTH:0]     trial;

    // Operand magnitudes. Negation happens only for signed, negative operands.
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .value_i  (dividend),
        .negate_i (op_signed & dividend[WIDTH-1]),
        .value_o  (abs_dvd)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
        .value_i  (divisor),
        .negate_i (op_signed & divisor[WIDTH-1]),
        .value_o  (abs_dvs)
    );

    // Result sign fix-up, applied in FIX.
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .value_i  (work_q[WIDTH-1:0]),
        .negate_i (neg_quo_q),
        .value_o  (fix_quo)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .value_i  (work_q[2*WIDTH-1:WIDTH]),
        .negate_i (neg_rem_q),
        .value_o  (fix_rem)
    );

    // The shifted partial remainder is WIDTH+1 bits wide. The bit shifted out
    // of the upper half is kept, so a divisor near 2^WIDTH-1 cannot overflow.
    assign trial = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};

    // NOTE: every variable gets its hold value before the case statement, so
    // a path that does not assign a variable cannot infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    neg_quo_d = op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = op_signed & dividend[WIDTH-1];
                    work_d    = {{WIDTH{1'b0}}, abs_dvd};
                    dvs_d     = abs_dvs;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`ifdef DIV_EARLY_ZERO_EN
                    else if (abs_dvd < abs_dvs) begin
                        quo_d   = '0;
                        rem_d   = dividend;
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end
`endif
                    else begin
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (!trial[WIDTH]) begin
                    work_d = {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_d = {work_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                quo_d   = fix_quo;
                rem_d   = fix_rem;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register in this block reads the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    // busy and done are decoded from the state only. Because of this, an
    // asynchronous reset clears both at once.
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign dataOut     = {rem_q, quo_q};
    assign div_by_zero = dbz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH = 32). Expected results come
// from plain integer division on 64-bit values. Latency is counted as clock
// edges after the accepting edge: WIDTH+1 for a full divide, 0 when the
// divide completes at the accepting edge.
// ----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic               clk;
    logic               reset;
    logic               start;
    logic               op_signed;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [2*WIDTH-1:0] dataOut;
    logic               div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_signed   (op_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .dataOut     (dataOut),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model. It uses plain arithmetic on 64-bit integers. SV
    // division truncates toward zero, and the remainder takes the sign of
    // the dividend.
    task automatic model(input bit s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                         output bit dbz, output int lat);
        longint sa, sb, ma, mb;
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1; lat = 0;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q   = 32'(sa / sb);
            r   = 32'(sa % sb);
            dbz = 1'b0;
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            lat = WIDTH + 1;
`ifdef DIV_EARLY_ZERO_EN
            if (ma < mb) lat = 0;
`endif
        end
    endtask

    // Runs one divide. When intrude is set, a second start with other
    // operands is pulsed while the divide is busy. That start must be ignored.
    task automatic run_div(input bit s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit intrude);
        logic [WIDTH-1:0] eq, er;
        bit  edbz;
        int  elat, edges, busy_low;
        model(s, a, b, eq, er, edbz, elat);
        @(negedge clk);
        start = 1'b1; op_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        op_signed = 1'($urandom_range(0, 1));
        dividend  = $urandom;
        divisor   = $urandom;
        edges = 0;
        busy_low = 0;
        while (!done && edges < 100) begin
            if (!busy) busy_low++;
            if (intrude && edges == 5) begin
                start = 1'b1; op_signed = 1'b0; dividend = 32'd1; divisor = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("latency", 64'(edges), 64'(elat));
        check("done_pulse", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd1);
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("dataOut", dataOut, {er, eq});
        check("div_by_zero", 64'(div_by_zero), 64'(edbz));
        if (intrude) check("busy_held", 64'(busy_low), 64'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        check("quotient_held", 64'(quotient), 64'(eq));
    endtask

    task automatic reset_mid_calc();
        int saw_done = 0;
        @(negedge clk);
        start = 1'b1; op_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("busy_before_reset", 64'(busy), 64'd1);
        #3 reset = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dataOut", dataOut, 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check("no_done_after_abort", 64'(saw_done), 64'd0);
        check("idle_after_abort", 64'(busy), 64'd0);
    endtask

    initial begin
        bit s;
        logic [WIDTH-1:0] a, b;
        int mode;
        reset = 1'b1; start = 1'b0; op_signed = 1'b0; dividend = '0; divisor = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dataOut", dataOut, 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 1'b0);
        run_div(1'b1, -32'sd7, 32'd2, 1'b0);
        run_div(1'b1, 32'd7, -32'sd2, 1'b0);
        run_div(1'b0, 32'h1234, 32'd0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        run_div(1'b0, 32'd3, 32'd9, 1'b0);
        run_div(1'b0, 32'd100, 32'd7, 1'b1);
        reset_mid_calc();
        run_div(1'b0, 32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            s    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 9);
            a    = (mode == 4) ? 32'($urandom_range(0, 20)) : $urandom;
            case (mode)
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = '1;
                default: b = $urandom;
            endcase
            run_div(s, a, b, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_divider
